div_clk_monitor: RTL

DIV_CLK_MONITOR -- requirements
Module: div_clk_monitor

---
 rtl/div_clk_monitor.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures period and high time of a clk-synchronous divided
// clock, checks them against an expected divide ratio and reports lock,
// sticky error and per-edge pulses.
module div_clk_monitor #(
  parameter  int unsigned MAX_N    = 256,
  parameter  int unsigned LOCK_CNT = 4,
  localparam int unsigned W        = $clog2(MAX_N + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] div_n,
  input  logic         clk_div_in,
  output logic         rise_pulse,
  output logic         fall_pulse,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         locked,
  output logic         err
);

  localparam int unsigned CW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

  localparam logic [W-1:0]  MAX_V     = W'(MAX_N);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_MEAS   = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  logic [1:0]    state_q,  state_d;
  logic          prev_q;
  logic [W-1:0]  pcnt_q,   pcnt_d;
  logic [W-1:0]  hcnt_q,   hcnt_d;
  logic [W-1:0]  period_q, period_d;
  logic [W-1:0]  high_q,   high_d;
  logic [CW-1:0] mcnt_q,   mcnt_d;
  logic          rise_q,   rise_d;
  logic          fall_q,   fall_d;
  logic          locked_q, locked_d;
  logic          err_q,    err_d;

  logic          rise_det;
  logic          fall_det;
  logic          active;
  logic          armed;
  logic          illegal;
  logic          pcnt_sat;
  logic          timeout;
  logic [W-1:0]  pcnt_inc;
  logic [W-1:0]  hcnt_inc;
  logic [W-1:0]  half_lo;
  logic [W-1:0]  half_hi;
  logic          period_match;

  // Edge detection, saturating increments and the per-period match decision.
  always_comb begin
    rise_det = clk_div_in & ~prev_q;
    fall_det = ~clk_div_in & prev_q;
    active   = en && (state_q != ST_IDLE);
    armed    = (state_q == ST_MEAS) || (state_q == ST_LOCKED);
    illegal  = div_n < W'(2);
    pcnt_sat = (pcnt_q == MAX_V);
    pcnt_inc = pcnt_sat ? pcnt_q : pcnt_q + W'(1);
    hcnt_inc = (hcnt_q == MAX_V) ? hcnt_q : hcnt_q + W'(1);
    timeout  = armed && pcnt_sat && !rise_det;
    half_lo  = div_n >> 1;
    half_hi  = half_lo + W'(div_n[0]);
    // pcnt_inc is the interval that closes on this rise (pcnt + 1, saturated)
    period_match = (pcnt_inc == div_n) &&
                   ((high_q == half_lo) || (high_q == half_hi));
  end

  // Period / high-time counters and the measurement registers they feed.
  always_comb begin
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    if (!active) begin
      pcnt_d = '0;
      hcnt_d = '0;
    end else begin
      pcnt_d = rise_det ? '0 : pcnt_inc;
      // the rise cycle itself is already a high cycle, so restart at 1
      if (rise_det) begin
        hcnt_d = W'(1);
      end else if (clk_div_in) begin
        hcnt_d = hcnt_inc;
      end
      if (armed && rise_det) begin
        period_d = pcnt_inc;
      end
      if (armed && fall_det) begin
        high_d = hcnt_q;
      end
    end
  end

  // Registered one-cycle edge pulses, suppressed while idle.
  always_comb begin
    rise_d = active && rise_det;
    fall_d = active && fall_det;
  end

  // Lock state machine with match counter and sticky error.
  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    err_d   = err_q;
    if (!en) begin
      state_d = ST_IDLE;
      mcnt_d  = '0;
      err_d   = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_ACQ;
      mcnt_d  = '0;
    end else if (illegal) begin
      state_d = ST_ACQ;
      mcnt_d  = '0;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        ST_ACQ: begin
          if (rise_det) begin
            state_d = ST_MEAS;
            mcnt_d  = '0;
          end
        end
        ST_MEAS: begin
          if (rise_det) begin
            if (period_match) begin
              if (mcnt_q == LOCK_LAST) begin
                state_d = ST_LOCKED;
                mcnt_d  = '0;
              end else begin
                mcnt_d = mcnt_q + CW'(1);
              end
            end else begin
              mcnt_d = '0;
            end
          end else if (timeout) begin
            state_d = ST_ACQ;
            mcnt_d  = '0;
            err_d   = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (rise_det) begin
            if (!period_match) begin
              state_d = ST_MEAS;
              mcnt_d  = '0;
              err_d   = 1'b1;
            end
          end else if (timeout) begin
            state_d = ST_ACQ;
            mcnt_d  = '0;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          mcnt_d  = '0;
        end
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      prev_q   <= 1'b0;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      mcnt_q   <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= clk_div_in;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      mcnt_q   <= mcnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign period     = period_q;
  assign high_time  = high_q;
  assign locked     = locked_q;
  assign err        = err_q;

endmodule
